adsr_envelope_poly: RTL and testbench
=====================================

// Module: adsr_envelope_poly
// PURPOSE
//  Parametrised multi-voice ADSR envelope generator, successor to the single-voice envelope block.
//  VOICES independent envelopes, each with linear segments (attack/decay/release).
//  Stages are advanced by a sample-rate tick enable.
//  Adds retrigger-from-current-value, zero-length-stage skip and per-voice status.
//  Sits between the note/voice allocator and the per-voice amplitude multipliers.
// PARAMETERS
//  VOICES  4   number of independent envelope channels
//  WIDTH   18  envelope level width, unsigned
//  CNT_W   32  stage duration / tick counter width
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst_b      in   1              synchronous active-low reset
//  tick       in   1              sample-rate enable; counters advance only when high
//  note_on    in   VOICES         per-voice one-cycle trigger
//  note_off   in   VOICES         per-voice one-cycle release request
//  lvl_a/b/c/d in  WIDTH each     start, peak, sustain, release-end levels (shared by all voices)
//  dur_x/y/z  in   CNT_W each     attack, decay, release durations in ticks
//  out_value  out  VOICES*WIDTH   voice v at [v*WIDTH +: WIDTH]
//  busy       out  VOICES         high while the voice is not IDLE
//  done       out  VOICES         one-cycle pulse when the voice returns to IDLE from RELEASE
// BEHAVIOUR
//  Reset (rst_b=0 at an edge)
//   - every voice goes to IDLE; counters, start registers and interp pipeline are cleared
//   - out_value=0, busy=0, done=0 from the next edge; a reset mid-stage never pulses done
//  Per-voice FSM, one-hot: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE
//   - IDLE->ATTACK on note_on; start=current out_value (retrigger), target=b, dur=x
//   - ATTACK/DECAY/SUSTAIN->RELEASE on note_off; start=current out_value, target=d, dur=z
//   - ATTACK->DECAY when tick && cnt+1>=x; DECAY->SUSTAIN when tick && cnt+1>=y
//   - DECAY uses start=b, target=c; SUSTAIN outputs c
//   - RELEASE->IDLE when tick && cnt+1>=z; done pulses in that same cycle; IDLE outputs a
//   - note_on in any non-IDLE state restarts ATTACK from the current out_value (no jump to a)
//   - note_on and note_off in the same cycle on one voice: note_on wins
//   - note_off in IDLE or RELEASE is ignored
//   - any state change clears cnt; otherwise cnt increments on tick only and saturates at all-ones
//   - dur==0 stage: the output equals target and the stage exits on the first tick
//  Arithmetic, per voice
//   - lvl = start + ((target-start)*cnt)/dur
//   - difference is signed WIDTH+1; product is signed WIDTH+1+CNT_W; divide truncates toward zero
//   - result is clamped to [0, 2^WIDTH-1]
//  Latency: out_value reflects the state/cnt registered at edge t at edge t+3, a fixed 3-stage pipeline
//   - busy and done are registered directly from the FSM and are not delayed
//  Voices are fully independent: no shared arbitration, and events on one voice never affect another
// STRUCTURE
//  Package env_pkg
//   - one-hot state localparams ST_IDLE..ST_RELEASE
//   - INTERP_LAT=3
//   - the interpolation function prototype for the bench model
//  Sub-module env_interp, one instance per voice via generate
//   - inputs: clk, rst_b, start, target, cnt, dur, hold, hold_val
//   - out: WIDTH level
//   - stages: subtract -> multiply -> divide+add+clamp
//   - hold selects hold_val, used for IDLE and SUSTAIN
//  The top level holds only the FSM array, the counters and the start/target/dur muxing
// TESTING (VOICES=4, WIDTH=18, tick=1 unless stated; a=0 b=1000 c=500 d=0 x=y=z=10)
//  1. note_on[0] pulse -> busy[0]=1 next edge; out0 ramps by 100/tick to 1000, decays to 500 over 10 ticks, holds 500
//  2. note_off[0] in SUSTAIN -> out0 500->0 over 10 ticks; done[0] one-cycle pulse; busy[0]=0; out0=a=0
//  3. note_on[1] during RELEASE at out1=250 -> ATTACK from 250 to 1000 in 10 ticks; no done[1] pulse
//  4. x=0, note_on[2] -> out2=1000 after pipeline latency, then decay to 500; y=0 also -> straight to SUSTAIN
//  5. tick=0 for 20 cycles mid-attack -> out frozen; rst_b=0 mid-decay -> all out_value/busy/done=0, IDLE
//  6. same-cycle note_on[3]+note_off[3] -> ATTACK; note_off[2] while IDLE -> no change

Source files
------------

// File: rtl/env_pkg.sv
// Shared types and constants for the polyphonic ADSR envelope generator.
// Also provides a reference interpolation function for behavioural models.
package env_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ATTACK  = 5'b00010,
        ST_DECAY   = 5'b00100,
        ST_SUSTAIN = 5'b01000,
        ST_RELEASE = 5'b10000
    } state_t;

    localparam int INTERP_LAT = 3;
    localparam int REF_WIDTH  = 18;
    localparam int REF_CNT_W  = 32;

    // lvl = start + ((target-start)*cnt)/dur, truncated toward zero, clamped to the level range
    function automatic logic [REF_WIDTH-1:0] env_interp_ref(
        input logic [REF_WIDTH-1:0] start,
        input logic [REF_WIDTH-1:0] target,
        input logic [REF_CNT_W-1:0] cnt,
        input logic [REF_CNT_W-1:0] dur
    );
        longint diff;
        longint lvl;
        if (dur == '0) return target;
        diff = longint'(target) - longint'(start);
        lvl  = longint'(start) + (diff * longint'(cnt)) / longint'(dur);
        if (lvl < 0) return '0;
        if (lvl > longint'({REF_WIDTH{1'b1}})) return '1;
        return lvl[REF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/adsr_envelope_interp.sv
// Three-stage linear interpolator for one envelope voice:
// subtract -> multiply -> divide, add and clamp.
module env_interp
    import env_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] start,
    input  logic [WIDTH-1:0] target,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] dur,
    input  logic             hold,
    input  logic [WIDTH-1:0] hold_val,
    output logic [WIDTH-1:0] level
);
    localparam int PW = WIDTH + 1 + CNT_W;

    logic signed [WIDTH:0]  s1_diff;
    logic [WIDTH-1:0]       s1_start, s1_target, s1_hold_val;
    logic [CNT_W-1:0]       s1_cnt, s1_dur;
    logic                   s1_hold;

    logic signed [PW-1:0]   s2_prod;
    logic [WIDTH-1:0]       s2_start, s2_target, s2_hold_val;
    logic [CNT_W-1:0]       s2_dur;
    logic                   s2_hold;

    logic signed [PW-1:0]   diff_ext, cnt_ext, prod, dur_ext, quot;
    logic signed [PW:0]     sum;
    logic [WIDTH-1:0]       clamped;

    assign diff_ext = {{CNT_W{s1_diff[WIDTH]}}, s1_diff};
    assign cnt_ext  = {{(WIDTH+1){1'b0}}, s1_cnt};
    assign prod     = diff_ext * cnt_ext;

    // A zero duration never reaches the divider result; the target is selected instead.
    assign dur_ext  = {{(WIDTH+1){1'b0}}, (s2_dur == '0) ? CNT_W'(1) : s2_dur};
    assign quot     = s2_prod / dur_ext;
    assign sum      = {quot[PW-1], quot} + {{(CNT_W+2){1'b0}}, s2_start};

    always_comb begin
        if (sum[PW])                       clamped = '0;
        else if (sum[PW-1:WIDTH] != '0)    clamped = '1;
        else                               clamped = sum[WIDTH-1:0];
    end

    // NOTE: pipeline registers use non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            s1_diff     <= '0;
            s1_start    <= '0;
            s1_target   <= '0;
            s1_hold_val <= '0;
            s1_cnt      <= '0;
            s1_dur      <= '0;
            s1_hold     <= 1'b0;
            s2_prod     <= '0;
            s2_start    <= '0;
            s2_target   <= '0;
            s2_hold_val <= '0;
            s2_dur      <= '0;
            s2_hold     <= 1'b0;
            level       <= '0;
        end else begin
            s1_diff     <= $signed({1'b0, target}) - $signed({1'b0, start});
            s1_start    <= start;
            s1_target   <= target;
            s1_hold_val <= hold_val;
            s1_cnt      <= cnt;
            s1_dur      <= dur;
            s1_hold     <= hold;
            s2_prod     <= prod;
            s2_start    <= s1_start;
            s2_target   <= s1_target;
            s2_hold_val <= s1_hold_val;
            s2_dur      <= s1_dur;
            s2_hold     <= s1_hold;
            if (s2_hold)             level <= s2_hold_val;
            else if (s2_dur == '0)   level <= s2_target;
            else                     level <= clamped;
        end
    end

endmodule

// File: rtl/adsr_envelope_poly.sv
// Multi-voice ADSR envelope generator: per-voice one-hot FSM, tick counter and
// segment selection feeding one pipelined interpolator per voice.
module adsr_envelope_poly
    import env_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int WIDTH  = 18,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    tick,
    input  logic [VOICES-1:0]       note_on,
    input  logic [VOICES-1:0]       note_off,
    input  logic [WIDTH-1:0]        lvl_a,
    input  logic [WIDTH-1:0]        lvl_b,
    input  logic [WIDTH-1:0]        lvl_c,
    input  logic [WIDTH-1:0]        lvl_d,
    input  logic [CNT_W-1:0]        dur_x,
    input  logic [CNT_W-1:0]        dur_y,
    input  logic [CNT_W-1:0]        dur_z,
    output logic [VOICES*WIDTH-1:0] out_value,
    output logic [VOICES-1:0]       busy,
    output logic [VOICES-1:0]       done
);

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] seg_dur;
        logic [WIDTH-1:0] start_q, level, seg_start, seg_target, hold_val;
        logic             hold, seg_end, busy_q, done_q;

        // NOTE: every output of this block gets a default first, so no latch is inferred.
        always_comb begin
            seg_start  = start_q;
            seg_target = lvl_a;
            seg_dur    = '0;
            hold       = 1'b1;
            hold_val   = lvl_a;
            unique case (state)
                ST_ATTACK:  begin seg_target = lvl_b; seg_dur = dur_x; hold = 1'b0; end
                ST_DECAY:   begin seg_start = lvl_b; seg_target = lvl_c; seg_dur = dur_y; hold = 1'b0; end
                ST_SUSTAIN: hold_val = lvl_c;
                ST_RELEASE: begin seg_target = lvl_d; seg_dur = dur_z; hold = 1'b0; end
                default:    hold_val = lvl_a;
            endcase
        end

        assign seg_end = tick && (({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, seg_dur});

        always_ff @(posedge clk) begin
            if (!rst_b) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                start_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (note_on[v]) begin
                    state   <= ST_ATTACK;
                    cnt     <= '0;
                    start_q <= level;
                    busy_q  <= 1'b1;
                end else if (note_off[v] && (state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
                    state   <= ST_RELEASE;
                    cnt     <= '0;
                    start_q <= level;
                end else if (seg_end && state == ST_ATTACK) begin
                    state <= ST_DECAY;
                    cnt   <= '0;
                end else if (seg_end && state == ST_DECAY) begin
                    state <= ST_SUSTAIN;
                    cnt   <= '0;
                end else if (seg_end && state == ST_RELEASE) begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else if (tick && cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        env_interp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_interp (
            .clk      (clk),
            .rst_b    (rst_b),
            .start    (seg_start),
            .target   (seg_target),
            .cnt      (cnt),
            .dur      (seg_dur),
            .hold     (hold),
            .hold_val (hold_val),
            .level    (level)
        );

        assign out_value[v*WIDTH +: WIDTH] = level;
        assign busy[v] = busy_q;
        assign done[v] = done_q;
    end

endmodule

// File: tb/tb_adsr_envelope_poly.sv
// Self-checking bench for adsr_envelope_poly: a hand-computed vector table for
// voice 0 plus a cycle model whose levels pass through a latency queue.
module tb_adsr_envelope_poly;
    import env_pkg::*;

    localparam int VOICES = 4;
    localparam int WIDTH  = 18;
    localparam int CNT_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst_b, tick;
    logic [VOICES-1:0]       note_on, note_off;
    logic [WIDTH-1:0]        lvl_a, lvl_b, lvl_c, lvl_d;
    logic [CNT_W-1:0]        dur_x, dur_y, dur_z;
    logic [VOICES*WIDTH-1:0] out_value;
    logic [VOICES-1:0]       busy, done;

    int total = 0;
    int bad   = 0;

    adsr_envelope_poly #(.VOICES(VOICES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_b(rst_b), .tick(tick), .note_on(note_on), .note_off(note_off),
        .lvl_a(lvl_a), .lvl_b(lvl_b), .lvl_c(lvl_c), .lvl_d(lvl_d),
        .dur_x(dur_x), .dur_y(dur_y), .dur_z(dur_z),
        .out_value(out_value), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef enum int {M_IDLE, M_ATT, M_DEC, M_SUS, M_REL} mstate_t;

    mstate_t                 m_st   [VOICES];
    logic [CNT_W-1:0]        m_cnt  [VOICES];
    logic [WIDTH-1:0]        m_start[VOICES];
    logic [WIDTH-1:0]        m_out  [VOICES];
    logic [VOICES-1:0]       m_busy, m_done;
    logic [VOICES*WIDTH-1:0] lvl_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_level(input int v);
        case (m_st[v])
            M_ATT:   return env_interp_ref(m_start[v], lvl_b, m_cnt[v], dur_x);
            M_DEC:   return env_interp_ref(lvl_b, lvl_c, m_cnt[v], dur_y);
            M_SUS:   return lvl_c;
            M_REL:   return env_interp_ref(m_start[v], lvl_d, m_cnt[v], dur_z);
            default: return lvl_a;
        endcase
    endfunction

    function automatic bool_end(input logic tk, input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
        return tk && (longint'(c) + 1 >= longint'(d));
    endfunction

    // Advance the model by one edge; push the new level, pop the one now due at the output.
    task automatic model_step(input logic [VOICES-1:0] on, input logic [VOICES-1:0] off,
                              input logic tk, input logic rb);
        logic [VOICES*WIDTH-1:0] lv;
        if (!rb) begin
            for (int v = 0; v < VOICES; v++) begin
                m_st[v] = M_IDLE; m_cnt[v] = '0; m_start[v] = '0; m_out[v] = '0;
            end
            m_busy = '0;
            m_done = '0;
            lvl_q.delete();
            repeat (INTERP_LAT) lvl_q.push_back('0);
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                m_done[v] = 1'b0;
                if (on[v]) begin
                    m_st[v] = M_ATT; m_cnt[v] = '0; m_start[v] = m_out[v];
                end else if (off[v] && (m_st[v] == M_ATT || m_st[v] == M_DEC || m_st[v] == M_SUS)) begin
                    m_st[v] = M_REL; m_cnt[v] = '0; m_start[v] = m_out[v];
                end else if (m_st[v] == M_ATT && bool_end(tk, m_cnt[v], dur_x)) begin
                    m_st[v] = M_DEC; m_cnt[v] = '0;
                end else if (m_st[v] == M_DEC && bool_end(tk, m_cnt[v], dur_y)) begin
                    m_st[v] = M_SUS; m_cnt[v] = '0;
                end else if (m_st[v] == M_REL && bool_end(tk, m_cnt[v], dur_z)) begin
                    m_st[v] = M_IDLE; m_cnt[v] = '0; m_done[v] = 1'b1;
                end else if (tk && m_cnt[v] != 32'hFFFF_FFFF) begin
                    m_cnt[v] = m_cnt[v] + 32'd1;
                end
                m_busy[v] = (m_st[v] != M_IDLE);
                lv[v*WIDTH +: WIDTH] = model_level(v);
            end
            lvl_q.push_back(lv);
            lv = lvl_q.pop_front();
            for (int v = 0; v < VOICES; v++) m_out[v] = lv[v*WIDTH +: WIDTH];
        end
    endtask

    task automatic step(input logic [VOICES-1:0] on, input logic [VOICES-1:0] off,
                        input logic tk, input logic rb);
        note_on  = on;
        note_off = off;
        tick     = tk;
        rst_b    = rb;
        model_step(on, off, tk, rb);
        @(posedge clk);
        @(negedge clk);
        for (int v = 0; v < VOICES; v++)
            check($sformatf("model_out%0d", v), 32'(out_value[v*WIDTH +: WIDTH]), 32'(m_out[v]));
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_done", 32'(done), 32'(m_done));
    endtask

    function automatic logic [31:0] out_of(input int v);
        return 32'(out_value[v*WIDTH +: WIDTH]);
    endfunction

    typedef struct {
        logic [VOICES-1:0] on;
        logic [VOICES-1:0] off;
        logic [WIDTH-1:0]  exp_out0;
        logic              exp_busy0;
        logic              exp_done0;
    } vec_t;

    vec_t vecs[41];

    // Hand-derived voice-0 level for the state registered at edge j of the table run.
    function automatic int hand_level(input int j);
        if (j < 10)  return 100 * j;
        if (j < 20)  return 1000 - 50 * (j - 10);
        if (j < 26)  return 500;
        if (j < 36)  return 500 - 50 * (j - 26);
        return 0;
    endfunction

    initial begin
        int done_cnt;
        note_on = '0; note_off = '0; tick = 1'b1; rst_b = 1'b0;
        lvl_a = 18'd0; lvl_b = 18'd1000; lvl_c = 18'd500; lvl_d = 18'd0;
        dur_x = 32'd10; dur_y = 32'd10; dur_z = 32'd10;

        for (int k = 0; k < 41; k++) begin
            vecs[k].on        = (k == 0)  ? 4'b0001 : 4'b0000;
            vecs[k].off       = (k == 26) ? 4'b0001 : 4'b0000;
            vecs[k].exp_out0  = (k < 3) ? 18'd0 : 18'(hand_level(k - 3));
            vecs[k].exp_busy0 = (k < 36);
            vecs[k].exp_done0 = (k == 36);
        end

        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out", 32'(out_value == '0), 32'd1);

        // Attack, decay, sustain, then release to idle on voice 0.
        for (int k = 0; k < 41; k++) begin
            step(vecs[k].on, vecs[k].off, 1'b1, 1'b1);
            check($sformatf("vec%0d_out0", k), out_of(0), 32'(vecs[k].exp_out0));
            check($sformatf("vec%0d_busy0", k), 32'(busy[0]), 32'(vecs[k].exp_busy0));
            check($sformatf("vec%0d_done0", k), 32'(done[0]), 32'(vecs[k].exp_done0));
        end

        // Retrigger voice 1 during release at level 250.
        step(4'b0010, '0, 1'b1, 1'b1);
        repeat (24) step('0, '0, 1'b1, 1'b1);
        step('0, 4'b0010, 1'b1, 1'b1);
        repeat (8) step('0, '0, 1'b1, 1'b1);
        check("retrig_pre_out1", out_of(1), 32'd250);
        step(4'b0010, '0, 1'b1, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            step('0, '0, 1'b1, 1'b1);
            if (done[1]) done_cnt++;
            if (i == 3) check("retrig_out1_step", out_of(1), 32'd325);
        end
        check("retrig_peak_out1", out_of(1), 32'd1000);
        check("retrig_no_done1", 32'(done_cnt), 32'd0);

        // Zero-length attack, then zero-length attack and decay, on voice 2.
        dur_x = 32'd0;
        step(4'b0100, '0, 1'b1, 1'b1);
        repeat (3) step('0, '0, 1'b1, 1'b1);
        check("x0_peak_out2", out_of(2), 32'd1000);
        repeat (22) step('0, '0, 1'b1, 1'b1);
        check("x0_sustain_out2", out_of(2), 32'd500);
        step('0, 4'b0100, 1'b1, 1'b1);
        repeat (15) step('0, '0, 1'b1, 1'b1);
        check("x0_idle_busy2", 32'(busy[2]), 32'd0);
        dur_y = 32'd0;
        step(4'b0100, '0, 1'b1, 1'b1);
        repeat (3) step('0, '0, 1'b1, 1'b1);
        check("xy0_peak_out2", out_of(2), 32'd1000);
        step('0, '0, 1'b1, 1'b1);
        check("xy0_sustain_out2", out_of(2), 32'd500);
        check("xy0_busy2", 32'(busy[2]), 32'd1);
        repeat (3) step('0, '0, 1'b1, 1'b1);
        dur_x = 32'd10;
        dur_y = 32'd10;

        // Freeze voice 0 mid-attack with tick low, then reset mid-decay.
        step(4'b0001, '0, 1'b1, 1'b1);
        repeat (5) step('0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step('0, '0, 1'b0, 1'b1);
            if (i >= 2) check("freeze_out0", out_of(0), 32'd500);
        end
        repeat (10) step('0, '0, 1'b1, 1'b1);
        check("middecay_busy0", 32'(busy[0]), 32'd1);
        step('0, '0, 1'b1, 1'b0);
        check("midrst_out", 32'(out_value == '0), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        step('0, '0, 1'b1, 1'b1);
        repeat (4) step('0, '0, 1'b1, 1'b1);
        check("post_rst_out0", out_of(0), 32'd0);

        // Simultaneous on/off on voice 3; note_off on idle voice 2.
        step(4'b1000, 4'b1000, 1'b1, 1'b1);
        check("onoff_busy3", 32'(busy[3]), 32'd1);
        step('0, 4'b0100, 1'b1, 1'b1);
        check("idle_off_busy2", 32'(busy[2]), 32'd0);
        repeat (6) step('0, '0, 1'b1, 1'b1);
        check("onoff_attack_out3", out_of(3), 32'd400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
